cp0_regfile: RTL
================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameter HW_INT_NUM, default 6: number of external hardware interrupt lines; legal range 1..6; line i maps to Cause.IP[i+2].
REQ-002 Parameter COUNT_DIV, default 2: clock cycles per Count increment; legal range 1..16.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- write_en  in  1  MTC0 write strobe
- read_en  in  1  MFC0 read strobe
- addr  in  8  {rd[4:0], sel[2:0]} register address
- write_data  in  32  MTC0 data
- read_data  out  32  MFC0 data
- hw_int  in  HW_INT_NUM  level-sensitive external interrupts
- exc_valid  in  1  exception commit strobe
- exc_code  in  5  Cause.ExcCode value
- exc_pc  in  32  PC of faulting instruction
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit strobe
- status_o  out  32  current Status
- cause_o  out  32  current Cause
- epc_o  out  32  current EPC
- int_pending  out  1  interrupt request to the pipeline

Function
REQ-004 Implemented registers: BadVAddr {8,0}, Count {9,0}, Compare {11,0}, Status {12,0}, Cause {13,0}, EPC {14,0}.
REQ-005 read_data SHALL be combinational from current register state when read_en=1, and 0 when read_en=0 or addr is unimplemented; a same-cycle write is not forwarded.
REQ-006 Writes SHALL take effect at the next rising edge; writes to unimplemented addresses and to BadVAddr SHALL be ignored.
REQ-007 Status writable bits: IM[15:8], EXL[1], IE[0]; Status[22] (BEV) reads 1; all other bits read 0.
REQ-008 Cause writable bits: IP[9:8] only; BD[31], TI[30], IP[15:10], and ExcCode[6:2] are hardware-controlled.
REQ-009 Cause.IP[7:2] (bits 15:10) SHALL register hw_int each cycle, one-cycle latency; unused lines read 0; IP[7] = hw_int[5] OR TI.
REQ-010 A prescaler SHALL increment Count once every COUNT_DIV cycles; Count wraps from 32'hFFFF_FFFF to 0.
REQ-011 A Count write SHALL load write_data, reset the prescaler to 0, and suppress that cycle's increment.
REQ-012 TI SHALL set in the cycle Count advances to a value equal to Compare, and stay set until a Compare write.
REQ-013 A Compare write SHALL clear TI; if a match occurs in the same cycle, the clear wins.
REQ-014 On exc_valid with EXL=0: set EXL=1; set BD=exc_in_delay_slot; set EPC=exc_in_delay_slot ? exc_pc-4 : exc_pc (mod 2^32).
REQ-015 On exc_valid with EXL=1, EPC and BD SHALL be unchanged.
REQ-016 On every exc_valid, ExcCode SHALL be loaded; BadVAddr SHALL be loaded only for exc_code 4 (AdEL) or 5 (AdES).
REQ-017 eret SHALL clear EXL.
REQ-018 Priority in the same cycle is exc_valid > eret > write_en; a lower-priority action to EXL/EPC/Cause is dropped, while writes to Count/Compare still apply.
REQ-019 int_pending = Status.IE AND NOT Status.EXL AND OR(Cause.IP[7:0] AND Status.IM[7:0]); combinational from registered state.

Reset
REQ-020 On rst at a clock edge: Status=32'h0040_0000, and Cause, EPC, BadVAddr, Count, Compare, and the prescaler = 0.
REQ-021 Under reset, all outputs SHALL be derived from the reset values: read_data=0 unless read, int_pending=0.
REQ-022 Reset SHALL override exc_valid, eret and write_en in the same cycle.

Structure
REQ-023 Shared package cp0_pkg SHALL hold the register addresses, ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12), Status/Cause bit positions, and reset values.
REQ-024 Sub-module cp0_timer SHALL contain the prescaler, Count, Compare and TI logic; Status, Cause, EPC, BadVAddr and the read mux remain in cp0_regfile.

Verification
REQ-025 Reset, then read {12,0} -> 32'h0040_0000; read {9,0} -> 0.
REQ-026 COUNT_DIV=2: write Count=32'hFFFF_FFFE, then wait 4 cycles -> Count=0 (wrap); set Compare=3, then wait 6 more cycles -> TI=1; write Compare -> TI=0 next cycle.
REQ-027 Write Status=32'h0000_8001, drive hw_int[5]=1 -> Cause bit15=1 after 1 cycle and int_pending=1; set EXL -> int_pending=0.
REQ-028 exc_valid with exc_pc=32'h8000_0104, delay slot=1, code=4, badvaddr=32'h1233 -> EPC=32'h8000_0100, BD=1, EXL=1, BadVAddr=32'h1233; a second exc_valid -> EPC unchanged.
REQ-029 Same cycle exc_valid=1, eret=1, and write Status IE=0 -> EXL=1, IE unchanged; next cycle eret alone -> EXL=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes,
// Status/Cause bit positions, write masks and reset values.
package cp0_pkg;

  // Register addresses, encoded as {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

  // Cause.ExcCode values
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Status bit positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IPSW_HI = 9;
  localparam int CAUSE_IPHW_LO = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  // Number of hardware interrupt slots in Cause.IP[7:2]
  localparam int HW_IP_SLOTS = 6;

  // Software-writable bits
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Reset values
  localparam logic [31:0] STATUS_RESET   = 32'h0040_0000;
  localparam logic [31:0] CAUSE_RESET    = 32'h0000_0000;
  localparam logic [31:0] EPC_RESET      = 32'h0000_0000;
  localparam logic [31:0] BADVADDR_RESET = 32'h0000_0000;
  localparam logic [31:0] COUNT_RESET    = 32'h0000_0000;
  localparam logic [31:0] COMPARE_RESET  = 32'h0000_0000;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaled Count, Compare, and the sticky timer interrupt TI.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] write_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // Prescaler terminal value; COUNT_DIV of 1 means a tick every cycle
  localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

  logic [3:0]  presc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  logic        tick;
  logic [31:0] count_inc;

  // Tick detection and the value Count would advance to
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    count_inc = count_q + 32'd1;
  end

  // Prescaler, Count, Compare and TI state; a Count write restarts the
  // prescaler and replaces the increment, a Compare write beats a match
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= 4'd0;
      count_q   <= COUNT_RESET;
      compare_q <= COMPARE_RESET;
      ti_q      <= 1'b0;
    end else begin
      if (count_we) begin
        count_q <= write_data;
        presc_q <= 4'd0;
      end else if (tick) begin
        count_q <= count_inc;
        presc_q <= 4'd0;
      end else begin
        presc_q <= presc_q + 4'd1;
      end

      if (compare_we) begin
        compare_q <= write_data;
        ti_q      <= 1'b0;
      end else if (tick && !count_we && (count_inc == compare_q)) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, the MFC0 read mux,
// exception/ERET sequencing and the interrupt request; timer in cp0_timer.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int HW_INT_NUM = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [7:0]            addr,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_in_delay_slot,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_pending
);

  // Status fields
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;

  // Cause fields
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  ip_sw_q;
  logic [HW_IP_SLOTS-1:0] ip_hw_q;

  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;

  // Timer interface
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        count_we;
  logic        compare_we;

  // Interrupt lines widened to the six Cause.IP hardware slots
  logic [HW_IP_SLOTS-1:0] hw_ext;
  logic        ip7;
  logic [31:0] epc_exc;

  // Timer writes are never blocked by exception or ERET
  always_comb begin
    count_we   = write_en && (addr == ADDR_COUNT);
    compare_we = write_en && (addr == ADDR_COMPARE);
    hw_ext     = HW_IP_SLOTS'(hw_int);
    epc_exc    = exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .write_data (write_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Architectural state: exception beats ERET beats MTC0 for EXL/EPC/Cause
  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= STATUS_RESET[STATUS_IM_HI:STATUS_IM_LO];
      exl_q      <= STATUS_RESET[STATUS_EXL];
      ie_q       <= STATUS_RESET[STATUS_IE];
      bd_q       <= CAUSE_RESET[CAUSE_BD];
      exc_code_q <= CAUSE_RESET[CAUSE_EXC_HI:CAUSE_EXC_LO];
      ip_sw_q    <= CAUSE_RESET[CAUSE_IPSW_HI:CAUSE_IP_LO];
      ip_hw_q    <= CAUSE_RESET[CAUSE_IP_HI:CAUSE_IPHW_LO];
      epc_q      <= EPC_RESET;
      badvaddr_q <= BADVADDR_RESET;
    end else begin
      ip_hw_q <= hw_ext;

      if (exc_valid) begin
        exc_code_q <= exc_code;
        if (is_addr_exc(exc_code)) begin
          badvaddr_q <= exc_badvaddr;
        end
        // A nested exception keeps the original return point
        if (!exl_q) begin
          exl_q <= 1'b1;
          bd_q  <= exc_in_delay_slot;
          epc_q <= epc_exc;
        end
      end else if (eret) begin
        exl_q <= 1'b0;
      end else if (write_en) begin
        case (addr)
          ADDR_STATUS: begin
            im_q  <= write_data[STATUS_IM_HI:STATUS_IM_LO];
            exl_q <= write_data[STATUS_EXL];
            ie_q  <= write_data[STATUS_IE];
          end
          ADDR_CAUSE: begin
            ip_sw_q <= write_data[CAUSE_IPSW_HI:CAUSE_IP_LO];
          end
          ADDR_EPC: begin
            epc_q <= write_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Register views; IP[7] is shared between hw_int[5] and the timer
  always_comb begin
    ip7      = ip_hw_q[5] | ti;
    status_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    cause_o  = {bd_q, ti, 14'd0, ip7, ip_hw_q[4:0], ip_sw_q, 1'b0,
                exc_code_q, 2'b00};
    epc_o    = epc_q;
  end

  // Interrupt request from registered state only
  always_comb begin
    int_pending = ie_q && !exl_q &&
                  (|(cause_o[CAUSE_IP_HI:CAUSE_IP_LO] & im_q));
  end

  // MFC0 read mux; unimplemented addresses and idle reads return 0
  always_comb begin
    read_data = 32'd0;
    if (read_en) begin
      case (addr)
        ADDR_BADVADDR: read_data = badvaddr_q;
        ADDR_COUNT:    read_data = count;
        ADDR_COMPARE:  read_data = compare;
        ADDR_STATUS:   read_data = status_o;
        ADDR_CAUSE:    read_data = cause_o;
        ADDR_EPC:      read_data = epc_q;
        default:       read_data = 32'd0;
      endcase
    end
  end

endmodule
